inner_chamber_port: RTL and testbench
=====================================

Name: inner_chamber_port

Overview:
Controller for the inner chamber port, the inner-side counterpart of the outer chamber port in the airlock. It takes the operator switch, the chamber evacuation state and the outer port's open status. It runs a timed open/close travel sequence and enforces the airlock interlock: the inner port never opens while the chamber is evacuated or the outer port is open. Its outputs feed the outer port interlock and the status display.

Parameters:
TRAVEL_CYCLES, 4, clock cycles for a full open or full close travel (minimum 2).
POS_W, 3, width of Position; must hold TRAVEL_CYCLES.

Ports:
Clock  input  1  system clock; all state updates on rising edge.
Reset  input  1  asynchronous, active-low reset.
SwitchFlip  input  1  operator switch level, asynchronous to Clock; 1 = command open, 0 = command closed.
EVState  input  1  chamber evacuated flag, synchronous to Clock; 1 = evacuated.
OuterOpen  input  1  outer port not fully closed, synchronous to Clock.
PortOpen  output  1  high only in state OPEN.
PortClosed  output  1  high only in state CLOSED.
Moving  output  1  high in OPENING or CLOSING.
Fault  output  1  sticky interlock-violation flag.
Position  output  POS_W  travel position; 0 = closed, TRAVEL_CYCLES = open.

Behaviour:
- Reset=0, asynchronously and without a clock edge:
  - state CLOSED, Position=0, Fault=0, synchronizer flops=0.
  - Outputs: PortClosed=1, PortOpen=0, Moving=0.
- Command synchronizer:
  - SwitchFlip passes through a 2-flop synchronizer; the FSM uses the second flop (cmd).
  - If SwitchFlip is first sampled at edge k, cmd changes at edge k+1 and the FSM acts on edge k+2.
- EVState and OuterOpen are used unsynchronized.
- Interlock ok = (EVState==0) and (OuterOpen==0).
- Outputs are Moore-decoded from registered state; Fault and Position are registered. There is no combinational input-to-output path.
- FSM states: CLOSED, OPENING, OPEN, CLOSING.
  - CLOSED: if cmd=1, ok=1 and Fault=0, go to OPENING with Position held at 0. Otherwise stay. A blocked request raises no fault.
  - OPENING:
    - On a violation (ok=0), go to CLOSING, set Fault=1, hold Position.
    - Else if cmd=0, go to CLOSING and hold Position (reversal from current position).
    - Else Position+1; the edge on which Position becomes TRAVEL_CYCLES also enters OPEN.
  - OPEN: on a violation (ok=0), go to CLOSING and set Fault=1. Else if cmd=0, go to CLOSING. Position stays TRAVEL_CYCLES.
  - CLOSING:
    - Position-1 each edge; the edge on which Position becomes 0 also enters CLOSED.
    - cmd=1 does not reverse a close; the FSM re-evaluates only after CLOSED is reached.
    - Violations during CLOSING are ignored (the port is already closing).
- Priority: violation over cmd=0. If both occur on the same edge, go to CLOSING with Fault=1.
- Fault clearing:
  - Fault clears on an edge where the state is CLOSED and cmd=0.
  - While Fault=1 with cmd=1 held, the port stays CLOSED. The operator must return the switch to 0 to acknowledge.
- Position never exceeds TRAVEL_CYCLES and never underflows below 0.
- Full open from CLOSED takes TRAVEL_CYCLES+1 edges after the FSM acts (one edge to enter OPENING, then TRAVEL_CYCLES increments).

Test Plan:
All scenarios use TRAVEL_CYCLES=4.
- Reset: hold Reset=0 with random inputs -> PortClosed=1, PortOpen=0, Moving=0, Fault=0, Position=0 immediately, before any clock edge.
- Normal open: EVState=0, OuterOpen=0, SwitchFlip=1 first sampled at edge k -> OPENING (Moving=1, Position=0) after edge k+2. Position is 1, 2, 3 at edges k+3 to k+5. Position=4 with PortOpen=1 at edge k+6. SwitchFlip=0 then closes in 4 edges to PortClosed=1.
- Reversal: drop SwitchFlip when Position=2 -> CLOSING with Position 2, 1, 0, then CLOSED. Fault stays 0.
- Blocked request: EVState=1, SwitchFlip=1 for 20 cycles -> CLOSED throughout, Fault=0. EVState->0 -> OPENING starts on the next edge.
- Violation: while OPEN, set OuterOpen=1 -> next edge CLOSING with Fault=1; CLOSED after 4 more edges.
  - With SwitchFlip still 1: stays CLOSED, Fault=1.
  - SwitchFlip=0: Fault=0 two edges later (after the synchronizer).
- Reset mid-travel: assert Reset=0 in OPENING at Position=3 -> immediate CLOSED outputs and Position=0. Release with SwitchFlip=1 -> a new open sequence after 3 edges.

Source files
------------

// File: rtl/inner_chamber_port.sv
// Inner airlock port controller: timed open/close travel with an evacuation and
// outer-port interlock, plus a sticky fault that the operator acknowledges.
module inner_chamber_port #(
    parameter int TRAVEL_CYCLES = 4,
    parameter int POS_W         = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             SwitchFlip,
    input  logic             EVState,
    input  logic             OuterOpen,
    output logic             PortOpen,
    output logic             PortClosed,
    output logic             Moving,
    output logic             Fault,
    output logic [POS_W-1:0] Position
);

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(TRAVEL_CYCLES);
    localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } state_t;

    state_t           state, state_n;
    logic             fault_n;
    logic [POS_W-1:0] pos_n;
    logic             sw_meta, cmd;
    logic             ok;

    // The switch is a raw operator input; only the second flop feeds the FSM.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sw_meta <= 1'b0;
            cmd     <= 1'b0;
        end else begin
            sw_meta <= SwitchFlip;
            cmd     <= sw_meta;
        end
    end

    assign ok = !EVState && !OuterOpen;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= CLOSED;
            Fault    <= 1'b0;
            Position <= '0;
        end else begin
            state    <= state_n;
            Fault    <= fault_n;
            Position <= pos_n;
        end
    end

    always_comb begin
        state_n = state;
        fault_n = Fault;
        pos_n   = Position;
        unique case (state)
            CLOSED: begin
                pos_n = '0;
                if (!cmd)
                    fault_n = 1'b0;
                else if (ok && !Fault)
                    state_n = OPENING;
            end
            OPENING: begin
                if (!ok) begin
                    state_n = CLOSING;
                    fault_n = 1'b1;
                end else if (!cmd) begin
                    state_n = CLOSING;
                end else begin
                    pos_n = Position + POS_ONE;
                    if (pos_n == POS_MAX)
                        state_n = OPEN;
                end
            end
            OPEN: begin
                pos_n = POS_MAX;
                if (!ok) begin
                    state_n = CLOSING;
                    fault_n = 1'b1;
                end else if (!cmd) begin
                    state_n = CLOSING;
                end
            end
            CLOSING: begin
                // A reversal right after leaving CLOSED can arrive here at 0.
                if (Position <= POS_ONE) begin
                    pos_n   = '0;
                    state_n = CLOSED;
                end else begin
                    pos_n = Position - POS_ONE;
                end
            end
            default: state_n = CLOSED;
        endcase
    end

    assign PortOpen   = (state == OPEN);
    assign PortClosed = (state == CLOSED);
    assign Moving     = (state == OPENING) || (state == CLOSING);

endmodule

// File: tb/tb_inner_chamber_port.sv
// Randomised and directed bench for inner_chamber_port against a direction/position
// model of the port travel.
module tb_inner_chamber_port;

    localparam int TC = 4;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       SwitchFlip, EVState, OuterOpen;
    logic       PortOpen, PortClosed, Moving, Fault;
    logic [2:0] Position;

    int total = 0;
    int bad   = 0;

    inner_chamber_port #(.TRAVEL_CYCLES(TC), .POS_W(3)) dut (
        .Clock(Clock), .Reset(Reset), .SwitchFlip(SwitchFlip), .EVState(EVState),
        .OuterOpen(OuterOpen), .PortOpen(PortOpen), .PortClosed(PortClosed),
        .Moving(Moving), .Fault(Fault), .Position(Position)
    );

    always #5 Clock = ~Clock;

    // Model: port as a position plus a travel direction (+1, -1, 0 = stationary).
    int m_pos, m_dir, m_fault, m_meta, m_cmd;

    logic [6:0] outs;
    assign outs = {PortOpen, PortClosed, Moving, Fault, Position};

    function automatic logic [6:0] exp_outs();
        logic op, cl, mv;
        op = (m_dir == 0) && (m_pos == TC);
        cl = (m_dir == 0) && (m_pos == 0);
        mv = (m_dir != 0);
        return {op, cl, mv, 1'(m_fault), 3'(m_pos)};
    endfunction

    task automatic model_reset();
        m_pos = 0; m_dir = 0; m_fault = 0; m_meta = 0; m_cmd = 0;
    endtask

    task automatic model_step();
        bit ok;
        ok = !EVState && !OuterOpen;
        if (m_dir == 0 && m_pos == 0) begin
            if (m_cmd == 0) m_fault = 0;
            else if (ok && m_fault == 0) m_dir = 1;
        end else if (m_dir >= 0 && !ok) begin
            m_dir = -1; m_fault = 1;
        end else if (m_dir >= 0 && m_cmd == 0) begin
            m_dir = -1;
        end else if (m_dir == 1) begin
            m_pos++;
            if (m_pos == TC) m_dir = 0;
        end else if (m_dir == -1) begin
            if (m_pos > 0) m_pos--;
            if (m_pos == 0) m_dir = 0;
        end
        m_cmd  = m_meta;
        m_meta = int'(SwitchFlip);
    endtask

    task automatic tick();
        @(posedge Clock);
        if (Reset) model_step(); else model_reset();
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        SwitchFlip = 1'($urandom); EVState = 1'($urandom); OuterOpen = 1'($urandom);
        model_reset();
        #2;
        total++;
        if (outs !== 7'b0100000) begin
            bad++; $display("FAIL reset_immediate got=%b want=%b", outs, 7'b0100000);
        end
        for (int i = 0; i < 3; i++) begin
            SwitchFlip = 1'($urandom); EVState = 1'($urandom); OuterOpen = 1'($urandom);
            tick();
            total++;
            if (outs !== exp_outs()) begin
                bad++; $display("FAIL reset_hold got=%b want=%b", outs, exp_outs());
            end
        end
        SwitchFlip = 0; EVState = 0; OuterOpen = 0;
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_normal_open();
        int exp_pos[7] = '{0, 0, 0, 1, 2, 3, 4};
        bit exp_mv[7]  = '{0, 0, 1, 1, 1, 1, 0};
        SwitchFlip = 1;
        for (int i = 0; i < 7; i++) begin
            tick();
            total++;
            if (outs !== exp_outs() || Position !== 3'(exp_pos[i]) || Moving !== exp_mv[i]) begin
                bad++; $display("FAIL open_edge%0d got=%b want=%b pos_want=%0d", i, outs, exp_outs(), exp_pos[i]);
            end
        end
        total++;
        if (PortOpen !== 1'b1) begin
            bad++; $display("FAIL open_reached got=%b want=1", PortOpen);
        end
        SwitchFlip = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            total++;
            if (outs !== exp_outs()) begin
                bad++; $display("FAIL close_edge%0d got=%b want=%b", i, outs, exp_outs());
            end
        end
        total++;
        if (PortClosed !== 1'b1 || Position !== 3'd0) begin
            bad++; $display("FAIL close_reached got closed=%b pos=%0d want closed=1 pos=0", PortClosed, Position);
        end
    endtask

    task automatic test_reversal();
        int maxpos = 0;
        bit seen = 0;
        SwitchFlip = 1;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (Moving && Position == 3'd0) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL reversal_start got=timeout want=opening");
        end
        SwitchFlip = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (int'(Position) > maxpos) maxpos = int'(Position);
            total++;
            if (outs !== exp_outs()) begin
                bad++; $display("FAIL reversal_edge%0d got=%b want=%b", i, outs, exp_outs());
            end
        end
        total++;
        if (maxpos != 2 || PortClosed !== 1'b1 || Fault !== 1'b0) begin
            bad++; $display("FAIL reversal_result got max=%0d closed=%b fault=%b want max=2 closed=1 fault=0",
                            maxpos, PortClosed, Fault);
        end
    endtask

    task automatic test_blocked();
        EVState = 1; SwitchFlip = 1;
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (PortClosed !== 1'b1 || Fault !== 1'b0 || outs !== exp_outs()) begin
                bad++; $display("FAIL blocked_cyc%0d got=%b want=%b", i, outs, exp_outs());
            end
        end
        EVState = 0;
        tick();
        total++;
        if (Moving !== 1'b1 || Position !== 3'd0) begin
            bad++; $display("FAIL blocked_release got mv=%b pos=%0d want mv=1 pos=0", Moving, Position);
        end
    endtask

    task automatic test_violation();
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (PortOpen) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL violation_open got=timeout want=open");
        end
        OuterOpen = 1;
        tick();
        total++;
        if (Moving !== 1'b1 || Fault !== 1'b1 || Position !== 3'd4) begin
            bad++; $display("FAIL violation_trip got=%b want mv=1 fault=1 pos=4", outs);
        end
        OuterOpen = 0;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (PortClosed !== 1'b1 || Fault !== 1'b1 || outs !== exp_outs()) begin
            bad++; $display("FAIL violation_closed got=%b want=%b", outs, exp_outs());
        end
        for (int i = 0; i < 6; i++) tick();
        total++;
        if (PortClosed !== 1'b1 || Fault !== 1'b1) begin
            bad++; $display("FAIL fault_held got closed=%b fault=%b want 1 1", PortClosed, Fault);
        end
        SwitchFlip = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (outs !== exp_outs()) begin
                bad++; $display("FAIL fault_ack_edge%0d got=%b want=%b", i, outs, exp_outs());
            end
        end
        total++;
        if (Fault !== 1'b0) begin
            bad++; $display("FAIL fault_clear got=%b want=0", Fault);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        SwitchFlip = 1;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            if (Moving && Position == 3'd3) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++; $display("FAIL midreset_reach got=timeout want=pos3");
        end
        #2 Reset = 0;
        model_reset();
        #1;
        total++;
        if (outs !== 7'b0100000) begin
            bad++; $display("FAIL midreset_immediate got=%b want=%b", outs, 7'b0100000);
        end
        @(negedge Clock);
        Reset = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (outs !== exp_outs() || Moving !== (i == 2)) begin
                bad++; $display("FAIL midreset_edge%0d got=%b want=%b", i, outs, exp_outs());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) SwitchFlip = ~SwitchFlip;
            EVState   = ($urandom_range(0, 19) == 0);
            OuterOpen = ($urandom_range(0, 19) == 0);
            tick();
            total++;
            if (outs !== exp_outs()) begin
                bad++; $display("FAIL random_cyc%0d got=%b want=%b", i, outs, exp_outs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_open();
        test_reversal();
        test_blocked();
        test_violation();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
